// File: rtl/count_history_display.sv
// count_history_display: keeps a 4-deep history of distinct 3-bit counter values
// (newest first), scans it onto a 4-digit active-low seven-segment display and
// counts 7->0 wrap events.
// Ports:
//   clk      - system clock, rising-edge active
//   rst      - asynchronous active-low reset
//   count_in - monitored counter value, synchronous to clk
//   seg      - segment drive, active-low, {g,f,e,d,c,b,a}
//   an       - digit anodes, active-low, one-hot-low
//   wrap_cnt - saturating count of 7->0 transitions
//   change   - one-cycle pulse on each history shift
module count_history_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        count_in,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              change
);
    localparam int               DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    // Glyphs for digits 7 down to 0, so element k is the glyph for k.
    localparam logic [7:0][6:0] SEG_LUT = {
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    logic [2:0]        r_prev;
    logic [3:0][2:0]   r_hist;
    logic [3:0]        r_hist_vld;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_dsel;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              r_change;

    logic              w_change;
    logic              w_wrap;
    logic              w_tick;
    logic [2:0]        w_digit;

    assign w_change = count_in != r_prev;
    assign w_wrap   = w_change && r_prev == 3'd7 && count_in == 3'd0;
    assign w_tick   = r_div == DIV_LAST;

    // Newest value enters slot 0; validity bits shift alongside the values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev     <= '0;
            r_hist     <= '0;
            r_hist_vld <= '0;
            r_change   <= 1'b0;
        end else begin
            r_change <= w_change;
            if (w_change) begin
                r_prev     <= count_in;
                r_hist     <= {r_hist[2:0], count_in};
                r_hist_vld <= {r_hist_vld[2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_wrap_cnt <= '0;
        else if (w_wrap && r_wrap_cnt != '1)
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_dsel <= '0;
        end else begin
            r_div  <= w_tick ? '0 : r_div + 1'b1;
            r_dsel <= w_tick ? r_dsel + 1'b1 : r_dsel;
        end
    end

    // Decode straight from registered state so a shift shows on the same cycle.
    always_comb begin
        w_digit = r_hist[r_dsel];
        seg     = r_hist_vld[r_dsel] ? SEG_LUT[w_digit] : 7'b1111111;
        an      = ~(4'b0001 << r_dsel);
    end

    assign wrap_cnt = r_wrap_cnt;
    assign change   = r_change;
endmodule

// File: tb/tb_count_history_display.sv
// tb_count_history_display: randomized and directed checks of count_history_display
// against a queue-based history model.
module tb_count_history_display;
    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] count_in = 3'd5;
    logic [6:0] seg, seg_s;
    logic [3:0] an, an_s;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_s;
    logic       change, change_s;

    count_history_display #(.REFRESH_DIV(RD), .WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .count_in(count_in),
        .seg(seg), .an(an), .wrap_cnt(wrap_cnt), .change(change)
    );

    count_history_display #(.REFRESH_DIV(RD), .WRAP_W(2)) dut_sat (
        .clk(clk), .rst(rst), .count_in(count_in),
        .seg(seg_s), .an(an_s), .wrap_cnt(wrap_s), .change(change_s)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    int tests = 0;
    int fails = 0;
    int q[$];
    int prev, wraps, ticks;
    bit exp_change;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        prev = 0;
        wraps = 0;
        ticks = 0;
        exp_change = 0;
    endtask

    task automatic check_all();
        int d;
        logic [6:0] e_seg;
        d = (ticks / RD) % 4;
        e_seg = (d < q.size()) ? seg_tab[q[d]] : 7'b1111111;
        chk("an", 32'(an), 32'(4'hf & ~(4'b0001 << d)));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("change", 32'(change), 32'(exp_change));
        chk("wrap_cnt", 32'(wrap_cnt), 32'((wraps > 255) ? 255 : wraps));
        chk("wrap_sat", 32'(wrap_s), 32'((wraps > 3) ? 3 : wraps));
    endtask

    task automatic tick(input int v);
        count_in = 3'(v);
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            exp_change = (v != prev);
            if (exp_change) begin
                if (prev == 7 && v == 0) wraps++;
                q.push_front(v);
                if (q.size() > 4) void'(q.pop_back());
                prev = v;
            end
            ticks++;
        end
        #1;
        check_all();
    endtask

    initial begin
        int v;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 3; i++) tick(5);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        tick(2);
        tick(3);
        for (int i = 0; i < 20; i++) tick(3);
        for (int p = 0; p < 10; p++)
            for (int k = 0; k < 8; k++) tick(k);
        tick(0);
        tick(6);
        tick(0);
        tick(7);
        tick(3);
        for (int i = 0; i < 300; i++) begin
            v = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) v = prev;
            else if (prev == 7 && $urandom_range(0, 1) == 1) v = 0;
            tick(v);
        end
        for (int k = 0; k < 8; k++) tick(k);
        tick(0);
        tick(2);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick(4);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) tick(i % 3 == 0 ? 4 : 5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
